// File: rtl/arb_types.sv
// Shared types and default widths for the instruction/data memory arbiter.
package arb_types;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Counter that increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port,
// alternating on ties and presenting only latched request fields to memory.
module mem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants
);

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              grant_i, grant_d;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, last_d_q==0 means instruction went last, so data wins.
                if ((d_read || d_write) && (!i_read || !last_d_q))
                    grant_d = 1'b1;
                else if (i_read)
                    grant_i = 1'b1;
                if (grant_d) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    wr_d     = d_write;
                end else if (grant_i) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = i_addr;
                    wr_d     = 1'b0;
                end
            end
            SERVE_I: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                mem_read  = !wr_q;
                mem_write = wr_q;
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

    sat_counter #(.W(CNT_W)) u_i_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (grant_i),
        .count_o (i_grants)
    );

    sat_counter #(.W(CNT_W)) u_d_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (grant_d),
        .count_o (d_grants)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: requesters push expected transactions, a negedge monitor
// pops and checks them whenever i_resp/d_resp fires.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk, rst;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [LW-1:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_resp, d_resp, mem_read, mem_write, mem_resp;
    logic [31:0]   i_grants, d_grants;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .i_grants(i_grants), .d_grants(d_grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    bit   glog[$];
    int   checks = 0;
    int   failures = 0;
    int   mem_lat = 3;
    bit   spur = 1'b0;

    function automatic logic [LW-1:0] rd_of(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [LW-1:0] wd_of(input logic [AW-1:0] a);
        return {4{a, ~a}};
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] log_bits();
        logic [15:0] v = '0;
        foreach (glog[k]) if (k < 16) v[k] = glog[k];
        return v;
    endfunction

    // Memory model: responds mem_lat cycles after a request first appears.
    initial begin
        int cyc = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_read || mem_write) begin
                cyc++;
                mem_resp  = (cyc == mem_lat);
                mem_rdata = (cyc == mem_lat) ? rd_of(mem_addr) : '0;
            end else begin
                cyc       = 0;
                mem_resp  = spur;
                mem_rdata = '0;
            end
        end
    end

    // Monitor
    initial begin
        bit   prev_resp = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_resp) chk("idle_gap", {mem_read, mem_write}, 2'b00);
            if (i_resp || d_resp) chk("resp_excl", i_resp & d_resp, 1'b0);
            if (i_resp) begin
                checks++;
                if (iq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_i_resp got=1 exp=0");
                end else begin
                    e = iq.pop_front();
                    chk("i_mem_addr", mem_addr, e.addr);
                    chk("i_mem_op", {mem_read, mem_write}, 2'b10);
                    chk("i_rdata", i_rdata, rd_of(e.addr));
                end
                glog.push_back(1'b0);
            end
            if (d_resp) begin
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_d_resp got=1 exp=0");
                end else begin
                    e = dq.pop_front();
                    chk("d_mem_addr", mem_addr, e.addr);
                    chk("d_mem_op", {mem_read, mem_write}, {!e.wr, e.wr});
                    if (e.wr) chk("d_mem_wdata", mem_wdata, e.wdata);
                    else      chk("d_rdata", d_rdata, rd_of(e.addr));
                end
                glog.push_back(1'b1);
            end
            prev_resp = i_resp | d_resp;
        end
    end

    // Requesters: caller positions at posedge+1; task returns at posedge+1 after resp.
    task automatic req_i(input logic [AW-1:0] a, input bit drop);
        int n = 0;
        i_read = 1'b1;
        i_addr = a;
        iq.push_back('{a, 1'b0, '0});
        while (n < 200) begin
            @(negedge clk);
            if (i_resp) break;
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL i_timeout got=none exp=i_resp");
        end
        @(posedge clk); #1;
        if (drop) i_read = 1'b0;
    endtask

    task automatic req_d(input logic [AW-1:0] a, input bit wr, input bit drop);
        int n = 0;
        d_read  = !wr;
        d_write = wr;
        d_addr  = a;
        d_wdata = wd_of(a);
        dq.push_back('{a, wr, wd_of(a)});
        while (n < 200) begin
            @(negedge clk);
            if (d_resp) break;
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL d_timeout got=none exp=d_resp");
        end
        @(posedge clk); #1;
        if (drop) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        iq.delete(); dq.delete(); glog.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_op", {mem_read, mem_write}, 2'b00);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_grants", i_grants, 0);
        chk("rst_d_grants", d_grants, 0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);

        // Single instruction fill, three wait cycles before mem_resp
        mem_lat = 4;
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 32'h100;
        iq.push_back('{32'h100, 1'b0, '0});
        @(negedge clk);
        chk("i1_pre_grant", mem_read, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("i1_mem_read", {mem_read, mem_write}, 2'b10);
            chk("i1_mem_addr", mem_addr, 32'h100);
            chk("i1_no_resp", i_resp, 1'b0);
        end
        @(negedge clk);
        chk("i1_resp", i_resp, 1'b1);
        @(posedge clk); #1;
        i_read = 1'b0;
        @(negedge clk);
        chk("i1_i_grants", i_grants, 1);
        chk("i1_d_grants", d_grants, 0);

        // Simultaneous i_read and d_write after reset: data first
        do_reset();
        mem_lat = 2;
        fork
            req_i(32'h400, 1'b1);
            req_d(32'h500, 1'b1, 1'b1);
        join
        chk("tie_count", glog.size(), 2);
        chk("tie_order", log_bits(), 16'b01);
        chk("tie_i_grants", i_grants, 1);
        chk("tie_d_grants", d_grants, 1);

        // Continuous contention: strict alternation D,I,D,I,D,I
        do_reset();
        mem_lat = 2;
        fork
            for (int k = 0; k < 3; k++) req_i(32'h1000 + k * 32'h40, k == 2);
            for (int m = 0; m < 3; m++) req_d(32'h2000 + m * 32'h40, m[0], m == 2);
        join
        chk("alt_count", glog.size(), 6);
        chk("alt_order", log_bits(), 16'b010101);
        chk("alt_i_grants", i_grants, 3);
        chk("alt_d_grants", d_grants, 3);

        // d_addr changes mid-service must not reach mem_addr
        do_reset();
        mem_lat = 5;
        fork
            req_d(32'h300, 1'b0, 1'b1);
            begin
                @(posedge clk); #2;
                d_addr = 32'hDEAD_BEE0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("hold_mem_addr", mem_addr, 32'h300);
                end
            end
        join

        // Stray mem_resp while idle is ignored
        do_reset();
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_idle_op", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
        end
        spur = 1'b0;
        chk("spur_grants", {i_grants, d_grants}, 64'h0);

        // Reset in SERVE_I abandons the transaction
        do_reset();
        mem_lat = 20;
        i_read = 1'b1; i_addr = 32'h200;
        repeat (2) @(negedge clk);
        chk("abort_serving", mem_read, 1'b1);
        chk("abort_pre_grants", i_grants, 1);
        @(posedge clk); #1;
        rst = 1'b1; i_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_op", {mem_read, mem_write}, 2'b00);
        chk("abort_grants", {i_grants, d_grants}, 64'h0);
        chk("abort_mem_addr", mem_addr, 0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_resp", {i_resp, d_resp}, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
